// File: rtl/rng_bit_collector.sv
// Ring-oscillator entropy consumer: warms up the oscillator, packs sampled bits into
// words, and runs repetition-count and adaptive-proportion health tests on every bit.
module rng_bit_collector #(
    parameter int WORD_W        = 64,
    parameter int WARMUP_CYCLES = 16,
    parameter int RCT_CUTOFF    = 32,
    parameter int APT_WINDOW    = 512,
    parameter int APT_CUTOFF    = 410
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic              osc_en,
    output logic              osc_sample_en,
    input  logic              raw_bit,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              health_fail,
    output logic [2:0]        dbg_state
);
    // Word handshake: word_data is stable while word_valid=1 and is consumed at the
    // first clock edge where word_valid and word_ready are both 1.

    typedef enum logic [2:0] {
        ST_IDLE, ST_WARMUP, ST_COLLECT, ST_HOLD, ST_FAIL
    } state_e;

    localparam int WARM_W = $clog2(WARMUP_CYCLES + 1);
    localparam int BIT_W  = $clog2(WORD_W + 1);
    localparam int RCT_W  = $clog2(RCT_CUTOFF + 1);
    localparam int APT_W  = $clog2(APT_CUTOFF + 1);
    localparam int POS_W  = $clog2(APT_WINDOW + 1);

    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);
    localparam logic [RCT_W-1:0]  RCT_LIM   = RCT_W'(RCT_CUTOFF);
    localparam logic [APT_W-1:0]  APT_LIM   = APT_W'(APT_CUTOFF);
    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(APT_WINDOW - 1);

    state_e             state_q;
    logic [WARM_W-1:0]  warm_cnt_q;
    logic [BIT_W-1:0]   bit_cnt_q;
    logic [RCT_W-1:0]   rct_cnt_q, rct_cnt_d;
    logic               last_bit_q, last_bit_d;
    logic [APT_W-1:0]   apt_cnt_q, apt_cnt_d;
    logic               apt_ref_q, apt_ref_d;
    logic [POS_W-1:0]   apt_pos_q, apt_pos_d;
    logic               fail_d;

    assign dbg_state = state_q;

    // Health-test update for the current raw_bit; applied only in COLLECT and HOLD.
    always_comb begin
        last_bit_d = raw_bit;
        if (rct_cnt_q == '0 || raw_bit != last_bit_q) begin
            rct_cnt_d = RCT_W'(1);
        end else begin
            rct_cnt_d = rct_cnt_q + RCT_W'(1);
        end
        if (apt_pos_q == '0) begin
            apt_ref_d = raw_bit;
            apt_cnt_d = APT_W'(1);
        end else begin
            apt_ref_d = apt_ref_q;
            apt_cnt_d = apt_cnt_q + APT_W'(raw_bit == apt_ref_q);
        end
        apt_pos_d = (apt_pos_q == POS_LAST) ? '0 : apt_pos_q + POS_W'(1);
        fail_d    = (rct_cnt_d == RCT_LIM) || (apt_cnt_d == APT_LIM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            osc_en        <= 1'b0;
            osc_sample_en <= 1'b0;
            word_valid    <= 1'b0;
            health_fail   <= 1'b0;
            word_data     <= '0;
            warm_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            rct_cnt_q     <= '0;
            last_bit_q    <= 1'b0;
            apt_cnt_q     <= '0;
            apt_ref_q     <= 1'b0;
            apt_pos_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q       <= ST_WARMUP;
                        osc_en        <= 1'b1;
                        osc_sample_en <= 1'b1;
                        warm_cnt_q    <= '0;
                        rct_cnt_q     <= '0;
                        apt_cnt_q     <= '0;
                        apt_pos_q     <= '0;
                    end
                end
                ST_WARMUP: begin
                    if (!enable) begin
                        state_q       <= ST_IDLE;
                        osc_en        <= 1'b0;
                        osc_sample_en <= 1'b0;
                    end else if (warm_cnt_q == WARM_LAST) begin
                        state_q   <= ST_COLLECT;
                        bit_cnt_q <= '0;
                    end else begin
                        warm_cnt_q <= warm_cnt_q + WARM_W'(1);
                    end
                end
                ST_COLLECT, ST_HOLD: begin
                    rct_cnt_q  <= rct_cnt_d;
                    last_bit_q <= last_bit_d;
                    apt_cnt_q  <= apt_cnt_d;
                    apt_ref_q  <= apt_ref_d;
                    apt_pos_q  <= apt_pos_d;
                    // A failing bit wins over packing, aborting and a same-cycle handshake.
                    if (fail_d) begin
                        state_q       <= ST_FAIL;
                        health_fail   <= 1'b1;
                        osc_en        <= 1'b0;
                        osc_sample_en <= 1'b0;
                        word_valid    <= 1'b0;
                    end else if (state_q == ST_COLLECT) begin
                        if (!enable) begin
                            state_q       <= ST_IDLE;
                            osc_en        <= 1'b0;
                            osc_sample_en <= 1'b0;
                            bit_cnt_q     <= '0;
                        end else begin
                            word_data <= {word_data[WORD_W-2:0], raw_bit};
                            if (bit_cnt_q == BIT_LAST) begin
                                state_q    <= ST_HOLD;
                                word_valid <= 1'b1;
                                bit_cnt_q  <= '0;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                            end
                        end
                    end else if (word_ready) begin
                        word_valid <= 1'b0;
                        bit_cnt_q  <= '0;
                        if (enable) begin
                            state_q <= ST_COLLECT;
                        end else begin
                            state_q       <= ST_IDLE;
                            osc_en        <= 1'b0;
                            osc_sample_en <= 1'b0;
                        end
                    end
                end
                ST_FAIL: begin
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rng_bit_collector.sv
// Bench for rng_bit_collector: directed scenarios plus random traffic, all checked
// against a bit-history reference model and a word scoreboard.
module tb_rng_bit_collector;
    localparam int WORD_W = 8;
    localparam int WARMUP = 4;
    localparam int RCT    = 4;
    localparam int APTW   = 16;
    localparam int APTC   = 12;

    localparam int MP_IDLE = 0;
    localparam int MP_WARM = 1;
    localparam int MP_COLL = 2;
    localparam int MP_HOLD = 3;
    localparam int MP_FAIL = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic raw_bit = 1'b0;
    logic word_ready = 1'b0;
    logic osc_en, osc_sample_en, word_valid, health_fail;
    logic [WORD_W-1:0] word_data;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_fail = 0;

    int m_ph = MP_IDLE;
    int m_warm = 0;
    bit hist[$];
    bit pack[$];
    logic [WORD_W-1:0] exp_q[$];
    logic prev_bit = 1'b0;

    rng_bit_collector #(
        .WORD_W(WORD_W), .WARMUP_CYCLES(WARMUP), .RCT_CUTOFF(RCT),
        .APT_WINDOW(APTW), .APT_CUTOFF(APTC)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .osc_en(osc_en), .osc_sample_en(osc_sample_en),
        .raw_bit(raw_bit), .word_data(word_data), .word_valid(word_valid),
        .word_ready(word_ready), .health_fail(health_fail), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WORD_W-1:0] got, input logic [WORD_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Health verdict from the whole tested-bit history since the last warmup.
    function automatic bit health_trip();
        int n = hist.size();
        int run = 1;
        int start;
        int cnt = 0;
        for (int i = n - 2; i >= 0 && hist[i] == hist[n-1]; i--) run++;
        start = ((n - 1) / APTW) * APTW;
        for (int i = start; i < n; i++) if (hist[i] == hist[start]) cnt++;
        return (run >= RCT) || (cnt >= APTC);
    endfunction

    task automatic model_step(input logic r, input logic e, input logic b, input logic rdy);
        logic [WORD_W-1:0] w;
        if (r) begin
            m_ph = MP_IDLE;
            hist.delete();
            pack.delete();
            exp_q.delete();
            return;
        end
        case (m_ph)
            MP_IDLE: if (e) begin m_ph = MP_WARM; m_warm = 0; hist.delete(); end
            MP_WARM: begin
                if (!e) m_ph = MP_IDLE;
                else begin
                    m_warm++;
                    if (m_warm == WARMUP) begin m_ph = MP_COLL; pack.delete(); end
                end
            end
            MP_COLL, MP_HOLD: begin
                hist.push_back(b);
                if (health_trip()) begin
                    m_ph = MP_FAIL;
                    exp_q.delete();
                end else if (m_ph == MP_COLL) begin
                    if (!e) m_ph = MP_IDLE;
                    else begin
                        pack.push_back(b);
                        if (pack.size() == WORD_W) begin
                            w = '0;
                            foreach (pack[i]) w = {w[WORD_W-2:0], pack[i]};
                            exp_q.push_back(w);
                            pack.delete();
                            m_ph = MP_HOLD;
                        end
                    end
                end else if (rdy) begin
                    m_ph = e ? MP_COLL : MP_IDLE;
                end
            end
            default: ;
        endcase
    endtask

    // One clock: drive inputs, score any handshake, advance the model, compare outputs.
    task automatic cycle(input logic r, input logic e, input logic b, input logic rdy);
        logic exp_on;
        @(negedge clk);
        rst = r; enable = e; raw_bit = b; word_ready = rdy;
        prev_bit = b;
        if (!r && word_valid && rdy) begin
            if (exp_q.size() == 0) check("word_unexpected", word_valid, 1'b0);
            else check("word_data", word_data, exp_q.pop_front());
        end
        model_step(r, e, b, rdy);
        @(posedge clk);
        #1;
        exp_on = (m_ph == MP_WARM) || (m_ph == MP_COLL) || (m_ph == MP_HOLD);
        check("osc_en", osc_en, exp_on);
        check("osc_sample_en", osc_sample_en, exp_on);
        check("word_valid", word_valid, m_ph == MP_HOLD);
        check("health_fail", health_fail, m_ph == MP_FAIL);
    endtask

    task automatic feed(input logic [31:0] bits, input int n, input logic e, input logic rdy);
        for (int i = n - 1; i >= 0; i--) cycle(1'b0, e, bits[i], rdy);
    endtask

    task automatic restart();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (WARMUP + 1) cycle(1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        // Reset then idle
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_data", word_data, '0);
        check("rst_state", dbg_state, 3'd0);
        repeat (20) cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Basic words at the minimum period
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        check("osc_on_first_edge", osc_en, 1'b1);
        repeat (WARMUP) cycle(1'b0, 1'b1, 1'b0, 1'b1);
        for (int w = 0; w < 2; w++) begin
            feed(32'hAA, 8, 1'b1, 1'b1);
            check("basic_valid", word_valid, 1'b1);
            check("basic_word", word_data, 8'hAA);
            cycle(1'b0, 1'b1, 1'b0, 1'b1);
        end

        // Backpressure in HOLD
        feed(32'hAA, 8, 1'b1, 1'b1);
        feed(32'h2AA, 10, 1'b1, 1'b0);
        check("bp_valid", word_valid, 1'b1);
        check("bp_word", word_data, 8'hAA);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        feed(32'h66, 8, 1'b1, 1'b1);
        check("bp_next_word", word_data, 8'h66);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        check("bp_no_alarm", health_fail, 1'b0);

        // RCT failure after four equal bits
        restart();
        feed(32'h8, 4, 1'b1, 1'b1);
        check("rct_before", health_fail, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        check("rct_alarm", health_fail, 1'b1);
        check("rct_osc_off", osc_en, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'(i % 2), 1'b1, 1'b1);
        check("rct_sticky", health_fail, 1'b1);

        // APT failure on the twelfth matching bit of a window
        restart();
        feed(32'h6DDD, 15, 1'b1, 1'b1);
        check("apt_before", health_fail, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        check("apt_alarm", health_fail, 1'b1);

        // Two windows of 11 matches each: the window restart keeps the alarm off
        restart();
        feed(32'hDBBA, 16, 1'b1, 1'b1);
        feed(32'hDBBA, 16, 1'b1, 1'b1);
        check("apt_window_restart", health_fail, 1'b0);

        // Mid-word abort and re-enable
        restart();
        feed(32'h16, 5, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("abort_osc_off", osc_en, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (WARMUP + 1) cycle(1'b0, 1'b1, 1'b0, 1'b1);
        feed(32'hCB, 8, 1'b1, 1'b1);
        check("abort_fresh_word", word_data, 8'hCB);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            logic r, e, b, rdy;
            r   = ($urandom_range(0, 39) == 0) || (m_ph == MP_FAIL && $urandom_range(0, 4) == 0);
            e   = ($urandom_range(0, 9) != 0);
            rdy = ($urandom_range(0, 9) < 7);
            b   = ($urandom_range(0, 9) < 6) ? ~prev_bit : prev_bit;
            cycle(r, e, b, rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
